// File: rtl/csi_lane_bitslip_ctrl_if.sv
// Lane-alignment bus between the bitslip sequencer and its surroundings.
// The master side owns the hunt enable and the deserializer word; the
// slave side (the sequencer) returns the BITSLIP pulse and the status.
interface csi_lane_bitslip_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                        en;
    logic [DATA_WIDTH-1:0]       data_in;
    logic                        bitslip;
    logic                        aligned;
    logic                        align_fail;
    logic [$clog2(DATA_WIDTH):0] slip_cnt;

    modport master (
        output en, data_in,
        input  bitslip, aligned, align_fail, slip_cnt
    );

    modport slave (
        input  en, data_in,
        output bitslip, aligned, align_fail, slip_cnt
    );
endinterface

// File: rtl/csi_lane_bitslip_ctrl.sv
// Word-alignment sequencer for one CSI-2 data lane deserializer.
// Runs on the deserializer's divided clock, pulses BITSLIP one position at a
// time until the HS sync byte shows up in the parallel word, then holds lock.
// Optional feature macro: BITSLIP_AUTO_RETRY_EN -- when defined, FAIL waits
// RETRY_WAIT cycles and starts a fresh hunt; when undefined, FAIL is sticky
// until en drops and the RETRY_WAIT parameter does not exist.
module csi_lane_bitslip_ctrl #(
    parameter int                    DATA_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_PATTERN  = DATA_WIDTH'(8'hB8),
    parameter int                    SETTLE_CYCLES = 3,
    parameter int                    SEARCH_WINDOW = 64
`ifdef BITSLIP_AUTO_RETRY_EN
    ,
    parameter int                    RETRY_WAIT    = 256
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    csi_lane_bitslip_ctrl_if.slave  bus
);

    localparam int CNT_W    = $clog2(DATA_WIDTH) + 1;
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int WIN_W    = $clog2(SEARCH_WINDOW + 1);

    localparam logic [CNT_W-1:0]    LAST_SLIP   = CNT_W'(DATA_WIDTH - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [WIN_W-1:0]    WIN_LOAD    = WIN_W'(SEARCH_WINDOW);

`ifdef BITSLIP_AUTO_RETRY_EN
    localparam int                 RETRY_W    = $clog2(RETRY_WAIT + 1);
    localparam logic [RETRY_W-1:0] RETRY_LOAD = RETRY_W'(RETRY_WAIT);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_SLIP,
        S_LOCKED,
        S_FAIL
    } state_t;

    state_t              state_q;
    logic                bitslip_q;
    logic                aligned_q;
    logic                align_fail_q;
    logic [CNT_W-1:0]    slip_cnt_q;
    logic [SETTLE_W-1:0] settle_cnt_q;
    logic [WIN_W-1:0]    window_cnt_q;
`ifdef BITSLIP_AUTO_RETRY_EN
    logic [RETRY_W-1:0]  retry_cnt_q;
`endif

    // Hunt sequencer: state, counters and registered status outputs together.
    // NOTE: every flop here is reset and assigned with <= only; the FSM reads
    // the old value of each counter in the same cycle it schedules the new one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bitslip_q    <= 1'b0;
            aligned_q    <= 1'b0;
            align_fail_q <= 1'b0;
            slip_cnt_q   <= '0;
            settle_cnt_q <= '0;
            window_cnt_q <= '0;
`ifdef BITSLIP_AUTO_RETRY_EN
            retry_cnt_q  <= '0;
`endif
        end else if (!bus.en) begin
            // Disable from any state abandons the hunt and clears all status.
            state_q      <= S_IDLE;
            bitslip_q    <= 1'b0;
            aligned_q    <= 1'b0;
            align_fail_q <= 1'b0;
            slip_cnt_q   <= '0;
            settle_cnt_q <= '0;
            window_cnt_q <= '0;
`ifdef BITSLIP_AUTO_RETRY_EN
            retry_cnt_q  <= '0;
`endif
        end else begin
            bitslip_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    slip_cnt_q   <= '0;
                    settle_cnt_q <= SETTLE_LOAD;
                    state_q      <= S_SETTLE;
                end
                S_SETTLE: begin
                    // Word is still garbage from the last slip; do not look at it.
                    if (settle_cnt_q == SETTLE_W'(1)) begin
                        window_cnt_q <= WIN_LOAD;
                        state_q      <= S_CHECK;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - SETTLE_W'(1);
                    end
                end
                S_CHECK: begin
                    // A match on the last window cycle still wins over slipping.
                    if (bus.data_in == SYNC_PATTERN) begin
                        aligned_q <= 1'b1;
                        state_q   <= S_LOCKED;
                    end else if (window_cnt_q == WIN_W'(1)) begin
                        if (slip_cnt_q < LAST_SLIP) begin
                            bitslip_q  <= 1'b1;
                            slip_cnt_q <= slip_cnt_q + CNT_W'(1);
                            state_q    <= S_SLIP;
                        end else begin
                            align_fail_q <= 1'b1;
`ifdef BITSLIP_AUTO_RETRY_EN
                            retry_cnt_q  <= RETRY_LOAD;
`endif
                            state_q      <= S_FAIL;
                        end
                    end else begin
                        window_cnt_q <= window_cnt_q - WIN_W'(1);
                    end
                end
                S_SLIP: begin
                    settle_cnt_q <= SETTLE_LOAD;
                    state_q      <= S_SETTLE;
                end
                S_LOCKED: begin
                    state_q <= S_LOCKED;
                end
                S_FAIL: begin
`ifdef BITSLIP_AUTO_RETRY_EN
                    if (retry_cnt_q == RETRY_W'(1)) begin
                        align_fail_q <= 1'b0;
                        slip_cnt_q   <= '0;
                        settle_cnt_q <= SETTLE_LOAD;
                        state_q      <= S_SETTLE;
                    end else begin
                        retry_cnt_q <= retry_cnt_q - RETRY_W'(1);
                    end
`else
                    state_q <= S_FAIL;
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The pulse is gated by en so a disable landing on the SLIP cycle
    // suppresses the slip in that same cycle, not one cycle late.
    assign bus.bitslip    = bitslip_q & bus.en;
    assign bus.aligned    = aligned_q;
    assign bus.align_fail = align_fail_q;
    assign bus.slip_cnt   = slip_cnt_q;

endmodule
